// File: rtl/vector_pkg.sv
// Shared types for the vector register file: lane geometry, the vector type
// and the hard-wired zero register index.
package vector_pkg;

  localparam int VEC_SIZE = 4;
  localparam int REG_SIZE = 16;
  localparam int REG_ZERO = 0;

  typedef logic [VEC_SIZE-1:0][REG_SIZE-1:0] vec_t;

endpackage

// File: rtl/vector_register_file_if.sv
// Decode-side issue/read bus and write-back bus of the vector register file.
// The pipeline drives it as master; the register file is the slave.
interface vector_register_file_if #(
  parameter int vecSize      = 4,
  parameter int registerSize = 16,
  parameter int regCount     = 16
);

  localparam int AW = $clog2(regCount);

  logic                                  issueValid;
  logic                                  issueWrites;
  logic [AW-1:0]                         rs1;
  logic [AW-1:0]                         rs2;
  logic [AW-1:0]                         rdIssue;
  logic                                  wbValid;
  logic [AW-1:0]                         wbAddr;
  logic [vecSize-1:0][registerSize-1:0]  writeBackData;
  logic [vecSize-1:0][registerSize-1:0]  rd1;
  logic [vecSize-1:0][registerSize-1:0]  rd2;
  logic                                  stall;
  logic                                  wbError;

  modport master (
    output issueValid, issueWrites, rs1, rs2, rdIssue,
    output wbValid, wbAddr, writeBackData,
    input  rd1, rd2, stall, wbError
  );

  modport slave (
    input  issueValid, issueWrites, rs1, rs2, rdIssue,
    input  wbValid, wbAddr, writeBackData,
    output rd1, rd2, stall, wbError
  );

endinterface

// File: rtl/vector_register_file_scoreboard.sv
// Per-register pending-write counters: decide when decode must stall and
// flag write-backs that nobody was waiting for.
module scoreboard
  import vector_pkg::*;
#(
  parameter  int regCount   = 16,
  parameter  int maxPending = 3,
  localparam int AW         = $clog2(regCount),
  localparam int CW         = $clog2(maxPending + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          issueValid,
  input  logic          issueWrites,
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic [AW-1:0] rdIssue,
  input  logic          wbValid,
  input  logic [AW-1:0] wbAddr,
  output logic          stall,
  output logic          wbError
);

  localparam logic [AW-1:0] zeroAddr = AW'(REG_ZERO);

  logic [CW-1:0] pending [regCount];
  logic [CW-1:0] eff1, eff2, effRd;
  logic          incValid, decValid;

  // A write-back landing this cycle already counts as retired for stall purposes.
  function automatic logic [CW-1:0] effOf(input logic [CW-1:0] p, input logic hit);
    return (hit && p != '0) ? p - CW'(1) : p;
  endfunction

  always_comb begin
    eff1  = effOf(pending[rs1], wbValid && wbAddr == rs1);
    eff2  = effOf(pending[rs2], wbValid && wbAddr == rs2);
    effRd = effOf(pending[rdIssue], wbValid && wbAddr == rdIssue);
    stall = issueValid &&
            ((rs1 != zeroAddr && eff1 != '0) ||
             (rs2 != zeroAddr && eff2 != '0) ||
             (issueWrites && rdIssue != zeroAddr && effRd == CW'(maxPending)));
  end

  assign incValid = issueValid && !stall && issueWrites && rdIssue != zeroAddr;
  assign decValid = wbValid && wbAddr != zeroAddr;

  // Issue and write-back to the same register in one cycle cancel out.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < regCount; r++) pending[r] <= '0;
      wbError <= 1'b0;
    end else begin
      for (int r = 0; r < regCount; r++) begin
        if (incValid && rdIssue == AW'(r) && !(decValid && wbAddr == AW'(r)))
          pending[r] <= pending[r] + CW'(1);
        else if (decValid && wbAddr == AW'(r) && !(incValid && rdIssue == AW'(r)) &&
                 pending[r] != '0)
          pending[r] <= pending[r] - CW'(1);
      end
      if (decValid && pending[wbAddr] == '0) wbError <= 1'b1;
    end
  end

endmodule

// File: rtl/vector_register_file.sv
// Vector register file fed by write-back: holds the data array, forwards a
// same-cycle write-back to the read ports and defers hazards to the scoreboard.
module vector_register_file
  import vector_pkg::*;
#(
  parameter  int vecSize      = 4,
  parameter  int registerSize = 16,
  parameter  int regCount     = 16,
  parameter  int maxPending   = 3,
  localparam int AW           = $clog2(regCount)
) (
  input logic                   clk,
  input logic                   reset,
  vector_register_file_if.slave bus
);

  localparam logic [AW-1:0] zeroAddr = AW'(REG_ZERO);

  logic [vecSize-1:0][registerSize-1:0] regs [regCount];

  // Register 0 is never written, so it keeps its reset value of zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int r = 0; r < regCount; r++) regs[r] <= '0;
    end else if (bus.wbValid && bus.wbAddr != zeroAddr) begin
      regs[bus.wbAddr] <= bus.writeBackData;
    end
  end

  always_comb begin
    bus.rd1 = regs[bus.rs1];
    bus.rd2 = regs[bus.rs2];
    if (bus.wbValid && bus.wbAddr == bus.rs1 && bus.rs1 != zeroAddr) bus.rd1 = bus.writeBackData;
    if (bus.wbValid && bus.wbAddr == bus.rs2 && bus.rs2 != zeroAddr) bus.rd2 = bus.writeBackData;
  end

  scoreboard #(
    .regCount   (regCount),
    .maxPending (maxPending)
  ) scoreboardInst (
    .clk         (clk),
    .reset       (reset),
    .issueValid  (bus.issueValid),
    .issueWrites (bus.issueWrites),
    .rs1         (bus.rs1),
    .rs2         (bus.rs2),
    .rdIssue     (bus.rdIssue),
    .wbValid     (bus.wbValid),
    .wbAddr      (bus.wbAddr),
    .stall       (bus.stall),
    .wbError     (bus.wbError)
  );

endmodule

// File: tb/tb_vector_register_file.sv
// Directed bench for vector_register_file: an integer/array model checked
// every cycle, plus hand-computed expectations along the scenarios.
module tb_vector_register_file;
  import vector_pkg::*;

  localparam int VS = 4;
  localparam int RS = 16;
  localparam int RC = 16;
  localparam int MP = 3;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic reset;
  int   testsRun = 0;
  int   testsFailed = 0;

  vector_register_file_if #(.vecSize(VS), .registerSize(RS), .regCount(RC)) bus ();

  vector_register_file #(
    .vecSize(VS), .registerSize(RS), .regCount(RC), .maxPending(MP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  vec_t vecA = {16'h1111, 16'h2222, 16'h3333, 16'h4444};
  vec_t vecB = {16'hBEEF, 16'h0007, 16'hCAFE, 16'h7007};
  vec_t vecC = {16'h9999, 16'h0009, 16'hA5A5, 16'h5A5A};
  vec_t vecF = {16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF};

  // Model state: outstanding writes per register, contents, sticky error.
  int   modelPending [RC];
  vec_t modelRegs [RC];
  bit   modelErr;

  function automatic void clearModel();
    for (int r = 0; r < RC; r++) begin
      modelPending[r] = 0;
      modelRegs[r] = '0;
    end
    modelErr = 1'b0;
  endfunction

  function automatic int effOf(int r);
    int p;
    p = modelPending[r];
    if (bus.wbValid && int'(bus.wbAddr) == r && p != 0) p--;
    return p;
  endfunction

  function automatic bit expStall();
    int a1, a2, ad;
    a1 = int'(bus.rs1);
    a2 = int'(bus.rs2);
    ad = int'(bus.rdIssue);
    return bus.issueValid &&
           ((a1 != 0 && effOf(a1) != 0) ||
            (a2 != 0 && effOf(a2) != 0) ||
            (bus.issueWrites && ad != 0 && effOf(ad) == MP));
  endfunction

  function automatic vec_t expRead(int r);
    if (r == 0) return '0;
    if (bus.wbValid && int'(bus.wbAddr) == r) return bus.writeBackData;
    return modelRegs[r];
  endfunction

  always @(posedge clk or negedge reset) begin
    bit inc, dec;
    int rd, wa;
    if (!reset) begin
      clearModel();
    end else begin
      rd  = int'(bus.rdIssue);
      wa  = int'(bus.wbAddr);
      inc = bus.issueValid && !expStall() && bus.issueWrites && rd != 0;
      dec = bus.wbValid && wa != 0;
      if (dec) begin
        modelRegs[wa] = bus.writeBackData;
        if (modelPending[wa] == 0) modelErr = 1'b1;
      end
      if (!(inc && dec && rd == wa)) begin
        if (inc) modelPending[rd]++;
        if (dec && modelPending[wa] > 0) modelPending[wa]--;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    testsRun++;
    if (actual !== expected) begin
      testsFailed++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", name, $time, actual, expected);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("cmpStall", 64'(bus.stall), 64'(expStall()));
    checkOutput("cmpRd1", bus.rd1, expRead(int'(bus.rs1)));
    checkOutput("cmpRd2", bus.rd2, expRead(int'(bus.rs2)));
    checkOutput("cmpWbError", 64'(bus.wbError), 64'(modelErr));
  end

  task automatic applyStimulus(input bit iv, input bit iw, input int r1, input int r2,
                               input int rdI, input bit wv, input int wa, input vec_t data);
    bus.issueValid    = iv;
    bus.issueWrites   = iw;
    bus.rs1           = AW'(r1);
    bus.rs2           = AW'(r2);
    bus.rdIssue       = AW'(rdI);
    bus.wbValid       = wv;
    bus.wbAddr        = AW'(wa);
    bus.writeBackData = data;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    clearModel();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #2 reset = 1'b1;

    nextCycle();
    applyStimulus(1, 0, 3, 5, 0, 0, 0, '0);
    #1;
    checkOutput("rstRd1", bus.rd1, 64'h0);
    checkOutput("rstRd2", bus.rd2, 64'h0);
    checkOutput("rstStall", 64'(bus.stall), 64'h0);
    checkOutput("rstWbError", 64'(bus.wbError), 64'h0);

    // RAW hazard on r4 released by a same-cycle write-back
    nextCycle();
    applyStimulus(1, 1, 0, 0, 4, 0, 0, '0);
    #1 checkOutput("issueR4Stall", 64'(bus.stall), 64'h0);
    nextCycle();
    applyStimulus(1, 0, 4, 0, 0, 0, 0, '0);
    #1 checkOutput("rawStall", 64'(bus.stall), 64'h1);
    nextCycle();
    applyStimulus(1, 0, 4, 0, 0, 1, 4, vecA);
    #1;
    checkOutput("wbReleaseStall", 64'(bus.stall), 64'h0);
    checkOutput("bypassRd1", bus.rd1, 64'h1111_2222_3333_4444);
    nextCycle();
    applyStimulus(1, 0, 4, 0, 0, 0, 0, '0);
    #1 checkOutput("storedRd1", bus.rd1, 64'h1111_2222_3333_4444);

    // Saturate r7 at maxPending
    repeat (3) begin
      nextCycle();
      applyStimulus(1, 1, 0, 0, 7, 0, 0, '0);
    end
    nextCycle();
    applyStimulus(1, 1, 0, 0, 7, 0, 0, '0);
    #1 checkOutput("fullStall", 64'(bus.stall), 64'h1);
    applyStimulus(1, 1, 0, 0, 7, 1, 7, vecB);
    #1 checkOutput("fullWbStall", 64'(bus.stall), 64'h0);
    nextCycle();
    applyStimulus(1, 1, 0, 0, 7, 0, 0, '0);
    #1 checkOutput("stillFullStall", 64'(bus.stall), 64'h1);
    repeat (3) begin
      nextCycle();
      applyStimulus(0, 0, 0, 0, 0, 1, 7, vecB);
    end
    nextCycle();
    applyStimulus(1, 0, 7, 0, 0, 0, 0, '0);
    #1;
    checkOutput("drainedStall", 64'(bus.stall), 64'h0);
    checkOutput("r7Rd1", bus.rd1, 64'hBEEF_0007_CAFE_7007);

    // Writes to register 0 are discarded and never flagged
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 1, 0, vecF);
    #1 checkOutput("zeroBypassRd1", bus.rd1, 64'h0);
    nextCycle();
    applyStimulus(1, 0, 0, 0, 0, 0, 0, '0);
    #1;
    checkOutput("zeroRd1", bus.rd1, 64'h0);
    checkOutput("zeroWbError", 64'(bus.wbError), 64'h0);

    // Unexpected write-back to r9
    nextCycle();
    applyStimulus(1, 0, 9, 0, 0, 1, 9, vecC);
    #1 checkOutput("orphanSameCycleErr", 64'(bus.wbError), 64'h0);
    nextCycle();
    applyStimulus(1, 0, 9, 0, 0, 0, 0, '0);
    #1;
    checkOutput("orphanErr", 64'(bus.wbError), 64'h1);
    checkOutput("orphanRd1", bus.rd1, 64'h9999_0009_A5A5_5A5A);
    checkOutput("orphanStall", 64'(bus.stall), 64'h0);
    repeat (3) nextCycle();
    checkOutput("stickyErr", 64'(bus.wbError), 64'h1);

    // Mid-cycle reset with writes pending on r2 and r3
    nextCycle();
    applyStimulus(1, 1, 0, 0, 2, 0, 0, '0);
    nextCycle();
    applyStimulus(1, 1, 0, 0, 3, 0, 0, '0);
    nextCycle();
    applyStimulus(1, 0, 2, 3, 0, 0, 0, '0);
    #1 checkOutput("preResetStall", 64'(bus.stall), 64'h1);
    reset = 1'b0;
    #1;
    checkOutput("resetStall", 64'(bus.stall), 64'h0);
    checkOutput("resetWbError", 64'(bus.wbError), 64'h0);
    nextCycle();
    reset = 1'b1;
    applyStimulus(1, 0, 9, 4, 0, 0, 0, '0);
    #1;
    checkOutput("postResetRd1", bus.rd1, 64'h0);
    checkOutput("postResetRd2", bus.rd2, 64'h0);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 1, 2, vecA);
    nextCycle();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, '0);
    #1 checkOutput("lateWbErr", 64'(bus.wbError), 64'h1);

    nextCycle();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
